// File: rtl/serial_adder_if.sv
// Serial adder request/result bundle.
// master drives start/a/b/cin; slave returns busy/done/sum/cout.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start,
    output a,
    output b,
    output cin,
    input  busy,
    input  done,
    input  sum,
    input  cout
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  cin,
    output busy,
    output done,
    output sum,
    output cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder, one bit per clock, LSB first.
// Ports: clk, rst_n (async, active-low), bus (serial_adder_if.slave).
module onebitadder (
  input  logic A,
  input  logic B,
  input  logic CarryIn,
  output logic Sum,
  output logic CarryOut
);
  assign Sum      = A ^ B ^ CarryIn;
  assign CarryOut = (A & B) | (CarryIn & (A ^ B));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cout_q;
  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             last;

  onebitadder u_fa (
    .A        (a_sh[0]),
    .B        (b_sh[0]),
    .CarryIn  (carry),
    .Sum      (fa_s),
    .CarryOut (fa_c)
  );

  // start is only honoured outside RUN
  assign accept = bus.start && (state != RUN);
  assign last   = (state == RUN) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.start) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        state_nx = bus.start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      psum   <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= bus.b;
      carry <= bus.cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      // sum bits enter at the MSB so bit 0 ends up at the LSB
      psum  <= {fa_s, psum[WIDTH-1:1]};
      carry <= fa_c;
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum_q  <= {fa_s, psum[WIDTH-1:1]};
        cout_q <= fa_c;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Serial adder bench: vector table, scoreboard queue, corner sequences.
// Drives on negedge, samples on negedge; 8-bit and 2-bit instances.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(2)) bus2 ();

  serial_adder #(.WIDTH(8)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_adder #(.WIDTH(2)) u2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int dones8 = 0;
  int dones2 = 0;
  logic [8:0] q8[$];
  logic [2:0] q2[$];
  logic [8:0] e8;
  logic [2:0] e2;
  logic [8:0] last9 = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus8.done === 1'b1) begin
      dones8++;
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8_unexpected: got done, required no pending op");
      end else begin
        e8 = q8.pop_front();
        chk("result8", 32'({bus8.cout, bus8.sum}), 32'(e8));
      end
    end
  end

  always @(negedge clk) begin
    if (bus2.done === 1'b1) begin
      dones2++;
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done2_unexpected: got done, required no pending op");
      end else begin
        e2 = q2.pop_front();
        chk("result2", 32'({bus2.cout, bus2.sum}), 32'(e2));
      end
    end
  end

  // drive at a negedge; accepted at the following posedge
  task automatic launch8(logic [7:0] a, logic [7:0] b, logic cin,
                         logic [8:0] exp);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = cin;
    q8.push_back(exp);
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    bus8.cin   = 1'($urandom);
  endtask

  task automatic wait8(logic [8:0] exp, int inject,
                       output int lat, output int bc);
    int n = 0;
    bc = 0;
    while (!(bus8.done === 1'b1) && n < 40) begin
      if (bus8.busy === 1'b1) bc++;
      if (n == 4)
        chk("hold8", 32'({bus8.cout, bus8.sum}), 32'(last9));
      if (n == inject) begin
        bus8.start = 1'b1;
        bus8.a     = 8'h11;
        bus8.b     = 8'h22;
      end else if (n == inject + 1) begin
        bus8.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    if (!(bus8.done === 1'b1)) begin
      checks++;
      errors++;
      $display("FAIL timeout8: got no done in %0d cycles, required 8", n);
    end
    last9 = exp;
    lat = n;
  endtask

  task automatic op8(logic [7:0] a, logic [7:0] b, logic cin,
                     logic [8:0] exp);
    int lat;
    int bc;
    launch8(a, b, cin, exp);
    wait8(exp, -1, lat, bc);
    chk("latency8", 32'(lat), 32'd8);
    chk("busy_cycles8", 32'(bc), 32'd8);
    @(negedge clk);
    chk("done_width8", 32'(bus8.done), 32'd0);
  endtask

  task automatic op2(logic [1:0] a, logic [1:0] b, logic cin);
    int n = 0;
    bus2.start = 1'b1;
    bus2.a     = a;
    bus2.b     = b;
    bus2.cin   = cin;
    q2.push_back(3'(a) + 3'(b) + 3'(cin));
    @(negedge clk);
    bus2.start = 1'b0;
    bus2.a     = ~a;
    bus2.b     = ~b;
    bus2.cin   = ~cin;
    while (!(bus2.done === 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency2", 32'(n), 32'd2);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    int lat;
    int bc;
    int d0;
    logic [7:0] ra;
    logic [7:0] rb;
    logic rc;

    tbl[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    tbl[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

    bus8.start = 1'b0;
    bus8.a = '0;
    bus8.b = '0;
    bus8.cin = 1'b0;
    bus2.start = 1'b0;
    bus2.a = '0;
    bus2.b = '0;
    bus2.cin = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_busy8", 32'(bus8.busy), 32'd0);
    chk("rst_done8", 32'(bus8.done), 32'd0);
    chk("rst_res8", 32'({bus8.cout, bus8.sum}), 32'd0);
    chk("rst_res2", 32'({bus2.cout, bus2.sum}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      op8(tbl[i].a, tbl[i].b, tbl[i].cin, {tbl[i].cout, tbl[i].sum});

    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      op8(ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc));
    end

    // start during RUN is ignored
    d0 = dones8;
    launch8(8'h12, 8'h34, 1'b0, 9'h046);
    wait8(9'h046, 3, lat, bc);
    chk("ignore_latency", 32'(lat), 32'd8);
    repeat (12) @(negedge clk);
    chk("ignore_done_count", 32'(dones8 - d0), 32'd1);

    // start held through the DONE cycle chains a second add
    launch8(8'h55, 8'h22, 1'b1, 9'h078);
    wait8(9'h078, -1, lat, bc);
    launch8(8'h03, 8'h04, 1'b0, 9'h007);
    chk("b2b_busy", 32'(bus8.busy), 32'd1);
    chk("b2b_done_low", 32'(bus8.done), 32'd0);
    wait8(9'h007, -1, lat, bc);
    chk("b2b_latency", 32'(lat), 32'd8);
    chk("b2b_busy_cycles", 32'(bc), 32'd8);
    @(negedge clk);

    // reset mid-RUN aborts
    op8(8'h9C, 8'h21, 1'b0, 9'h0BD);
    launch8(8'h40, 8'h41, 1'b1, 9'h082);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus8.busy), 32'd0);
    chk("abort_done", 32'(bus8.done), 32'd0);
    chk("abort_res", 32'({bus8.cout, bus8.sum}), 32'd0);
    q8.delete();
    last9 = '0;
    d0 = dones8;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op8(8'hC3, 8'h3C, 1'b1, 9'h100);
    repeat (12) @(negedge clk);
    chk("abort_done_count", 32'(dones8 - d0), 32'd1);

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++)
          op2(2'(a), 2'(b), 1'(c));

    repeat (4) @(negedge clk);
    chk("q8_empty", 32'(q8.size()), 32'd0);
    chk("q2_empty", 32'(q2.size()), 32'd0);
    chk("dones2", 32'(dones2), 32'd32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
